// File: rtl/deser_framed.sv
// deser_framed: serial-to-parallel deserializer with start-of-frame alignment,
// a single-entry output holding register with valid/ready handshake, and a
// sticky overflow flag for completed words that could not be stored.
module deser_framed #(
    parameter int DATA_WIDTH = 16,
    parameter int MSB_FIRST  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          din,
    input  logic                          din_valid,
    input  logic                          din_sof,
    output logic [DATA_WIDTH-1:0]         dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic [$clog2(DATA_WIDTH)-1:0] bit_count
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    // Shift one serial bit into a partial word in the configured bit order.
    // MSB-first shifts left so the earliest bit ends up in the top position;
    // LSB-first shifts right so the earliest bit ends up in bit 0.
    function automatic logic [DATA_WIDTH-1:0] shift_in(
        input logic [DATA_WIDTH-1:0] cur,
        input logic                  b
    );
        logic [DATA_WIDTH-1:0] res;
        if (MSB_FIRST != 0) begin
            res = {cur[DATA_WIDTH-2:0], b};
        end else begin
            res = {b, cur[DATA_WIDTH-1:1]};
        end
        return res;
    endfunction

    logic [DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dout_valid;
    logic                  r_overflow;

    logic [DATA_WIDTH-1:0] w_shift_next;
    logic [CW-1:0]         w_cnt_next;
    logic                  w_complete;
    logic                  w_consume;
    logic                  w_load;
    logic                  w_drop;

    // Next partial word, bit counter and word-completion detection.
    always_comb begin
        w_shift_next = r_shift;
        w_cnt_next   = r_cnt;
        w_complete   = 1'b0;
        if (din_valid) begin
            if (din_sof) begin
                // Frame start: drop any partial, this bit is bit 0 of a new word.
                w_shift_next = shift_in({DATA_WIDTH{1'b0}}, din);
                w_cnt_next   = ONE_CNT;
            end else begin
                w_shift_next = shift_in(r_shift, din);
                if (r_cnt == LAST_IDX) begin
                    w_complete = 1'b1;
                    w_cnt_next = {CW{1'b0}};
                end else begin
                    w_cnt_next = r_cnt + ONE_CNT;
                end
            end
        end else begin
            w_shift_next = r_shift;
            w_cnt_next   = r_cnt;
        end
    end

    // Output-register decisions: consume, load (possibly same edge), or drop.
    always_comb begin
        w_consume = r_dout_valid & dout_ready;
        w_load    = 1'b0;
        w_drop    = 1'b0;
        if (w_complete) begin
            if (!r_dout_valid || dout_ready) begin
                w_load = 1'b1;
            end else begin
                w_drop = 1'b1;
            end
        end else begin
            w_load = 1'b0;
            w_drop = 1'b0;
        end
    end

    // Serial-side state: shift register and bit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift <= {DATA_WIDTH{1'b0}};
            r_cnt   <= {CW{1'b0}};
        end else begin
            r_shift <= w_shift_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Holding register: changes only on a load or a completed handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout       <= {DATA_WIDTH{1'b0}};
            r_dout_valid <= 1'b0;
        end else if (w_load) begin
            r_dout       <= w_shift_next;
            r_dout_valid <= 1'b1;
        end else if (w_consume) begin
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= r_dout_valid;
        end
    end

    // Sticky overflow; a drop on the same edge as a clear leaves it set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (overflow_clr) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_overflow;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign overflow   = r_overflow;
    assign bit_count  = r_cnt;

endmodule

// File: tb/tb_deser_framed.sv
// Testbench for deser_framed: MSB-first and LSB-first instances (8-bit) share
// stimulus and are checked against a queue-based reference model.
module tb_deser_framed;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       din_sof = 1'b0;
    logic       dout_ready = 1'b0;
    logic       overflow_clr = 1'b0;

    logic [7:0] dout_m, dout_l;
    logic       valid_m, valid_l, ovf_m, ovf_l;
    logic [2:0] bc_m, bc_l;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: accepted bits of the current partial word, plus the
    // expected holding-register contents for each bit order.
    bit         mq[$];
    logic [7:0] m_dout_m = 8'h00;
    logic [7:0] m_dout_l = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ovf = 1'b0;

    always #5 clk = ~clk;

    deser_framed #(.DATA_WIDTH(8), .MSB_FIRST(1)) u_msb (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_sof(din_sof),
        .dout(dout_m), .dout_valid(valid_m), .dout_ready(dout_ready),
        .overflow(ovf_m), .overflow_clr(overflow_clr), .bit_count(bc_m)
    );

    deser_framed #(.DATA_WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_sof(din_sof),
        .dout(dout_l), .dout_valid(valid_l), .dout_ready(dout_ready),
        .overflow(ovf_l), .overflow_clr(overflow_clr), .bit_count(bc_l)
    );

    // Advance the model with the current inputs, then clock and settle.
    task automatic tick();
        logic       cons, cmp, drop;
        logic [7:0] wm, wl;
        cmp = 1'b0;
        wm = 8'h00;
        wl = 8'h00;
        if (reset) begin
            mq.delete();
            m_dout_m = 8'h00;
            m_dout_l = 8'h00;
            m_valid = 1'b0;
            m_ovf = 1'b0;
        end else begin
            cons = m_valid && dout_ready;
            if (din_valid) begin
                if (din_sof) mq.delete();
                mq.push_back(din);
                if (!din_sof && mq.size() == 8) begin
                    cmp = 1'b1;
                    for (int i = 0; i < 8; i++) begin
                        wm[7-i] = mq[i];
                        wl[i] = mq[i];
                    end
                    mq.delete();
                end
            end
            drop = cmp && m_valid && !dout_ready;
            if (cmp && !drop) begin
                m_valid = 1'b1;
                m_dout_m = wm;
                m_dout_l = wl;
            end else if (cons) begin
                m_valid = 1'b0;
            end
            if (drop) m_ovf = 1'b1;
            else if (overflow_clr) m_ovf = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic sof);
        din = b;
        din_valid = 1'b1;
        din_sof = sof;
        tick();
        din_valid = 1'b0;
        din_sof = 1'b0;
    endtask

    task automatic send_word_msb(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i], 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_cmp++;
        if (dout_m !== 8'h00 || dout_l !== 8'h00) begin
            n_err++; $display("FAIL reset_dout got %h/%h exp 00/00", dout_m, dout_l);
        end
        n_cmp++;
        if (valid_m !== 1'b0 || valid_l !== 1'b0) begin
            n_err++; $display("FAIL reset_valid got %b/%b exp 0/0", valid_m, valid_l);
        end
        n_cmp++;
        if (ovf_m !== 1'b0 || bc_m !== 3'd0 || bc_l !== 3'd0) begin
            n_err++; $display("FAIL reset_ovf_bc got ovf=%b bc=%0d/%0d exp 0,0/0", ovf_m, bc_m, bc_l);
        end
    endtask

    task automatic test_msb_a5();
        logic [7:0] pat = 8'hA5;
        dout_ready = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            send_bit(pat[i], 1'b0);
            n_cmp++;
            if (bc_m !== 3'(mq.size())) begin
                n_err++; $display("FAIL a5_bit_count got %0d exp %0d", bc_m, mq.size());
            end
        end
        n_cmp++;
        if (valid_m !== 1'b1 || dout_m !== 8'hA5 || dout_m !== m_dout_m) begin
            n_err++; $display("FAIL a5_word got v=%b %h exp v=1 a5", valid_m, dout_m);
        end
        tick();
        n_cmp++;
        if (valid_m !== 1'b0 || valid_l !== m_valid) begin
            n_err++; $display("FAIL a5_one_cycle got v=%b/%b exp 0/0", valid_m, valid_l);
        end
    endtask

    task automatic test_lsb_0f();
        logic [7:0] s = 8'b1111_0000;
        dout_ready = 1'b1;
        for (int i = 7; i >= 0; i--) send_bit(s[i], 1'b0);
        n_cmp++;
        if (valid_l !== 1'b1 || dout_l !== 8'h0F || dout_l !== m_dout_l) begin
            n_err++; $display("FAIL lsb_0f got v=%b %h exp v=1 0f", valid_l, dout_l);
        end
        n_cmp++;
        if (dout_m !== 8'hF0) begin
            n_err++; $display("FAIL lsb_msb_peer got %h exp f0", dout_m);
        end
        tick();
    endtask

    task automatic test_overflow();
        dout_ready = 1'b0;
        send_word_msb(8'h12);
        n_cmp++;
        if (valid_m !== 1'b1 || dout_m !== 8'h12 || ovf_m !== 1'b0) begin
            n_err++; $display("FAIL ovf_first got v=%b %h ovf=%b exp 1 12 0", valid_m, dout_m, ovf_m);
        end
        send_word_msb(8'h34);
        n_cmp++;
        if (dout_m !== 8'h12 || ovf_m !== 1'b1 || ovf_l !== m_ovf) begin
            n_err++; $display("FAIL ovf_second got %h ovf=%b exp 12 1", dout_m, ovf_m);
        end
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        n_cmp++;
        if (ovf_m !== 1'b0 || valid_m !== 1'b1) begin
            n_err++; $display("FAIL ovf_clear got ovf=%b v=%b exp 0 1", ovf_m, valid_m);
        end
        dout_ready = 1'b1;
        tick();
        n_cmp++;
        if (valid_m !== 1'b0 || dout_m !== 8'h12) begin
            n_err++; $display("FAIL ovf_drain got v=%b %h exp 0 12", valid_m, dout_m);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] s = 16'hC33C;
        int gaps = 0;
        dout_ready = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            send_bit(s[i], 1'b0);
            if (i == 8 || i == 0) begin
                n_cmp++;
                if (valid_m !== 1'b1 || dout_m !== ((i == 8) ? 8'hC3 : 8'h3C) || ovf_m !== 1'b0) begin
                    n_err++; $display("FAIL b2b_word got v=%b %h ovf=%b exp 1 %h 0",
                        valid_m, dout_m, ovf_m, (i == 8) ? 8'hC3 : 8'h3C);
                end
            end
        end
        tick();
        // Held word consumed on the very edge the next word completes.
        dout_ready = 1'b0;
        send_word_msb(8'hC3);
        for (int i = 7; i >= 0; i--) begin
            dout_ready = (i == 0);
            send_bit(s[i], 1'b0);
            if (valid_m !== 1'b1) gaps++;
        end
        n_cmp++;
        if (gaps != 0 || dout_m !== 8'h3C || ovf_m !== 1'b0 || dout_l !== m_dout_l) begin
            n_err++; $display("FAIL b2b_nogap got gaps=%0d %h ovf=%b exp 0 3c 0", gaps, dout_m, ovf_m);
        end
        dout_ready = 1'b1;
        tick();
        n_cmp++;
        if (valid_m !== 1'b0) begin
            n_err++; $display("FAIL b2b_drain got v=%b exp 0", valid_m);
        end
    endtask

    task automatic test_sof();
        logic [7:0] w = 8'h81;
        int nwords = 0;
        logic [7:0] seen = 8'h00;
        dout_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1'b0);
        send_bit(w[7], 1'b1);
        n_cmp++;
        if (bc_m !== 3'd1 || bc_l !== 3'd1 || valid_m !== 1'b0) begin
            n_err++; $display("FAIL sof_bit_count got %0d/%0d v=%b exp 1/1 0", bc_m, bc_l, valid_m);
        end
        for (int i = 6; i >= 0; i--) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                din = 1'($urandom);
                din_sof = 1'($urandom);
                tick();
                din_sof = 1'b0;
                if (valid_m === 1'b1) begin nwords++; seen = dout_m; end
            end
            send_bit(w[i], 1'b0);
            if (valid_m === 1'b1) begin nwords++; seen = dout_m; end
        end
        tick();
        n_cmp++;
        if (nwords != 1 || seen !== 8'h81 || seen !== m_dout_m) begin
            n_err++; $display("FAIL sof_word got n=%0d %h exp 1 81", nwords, seen);
        end
    endtask

    task automatic test_reset_mid();
        dout_ready = 1'b0;
        send_word_msb(8'h5A);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        n_cmp++;
        if (valid_m !== 1'b1 || bc_m !== 3'd4) begin
            n_err++; $display("FAIL rmid_pre got v=%b bc=%0d exp 1 4", valid_m, bc_m);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (dout_m !== 8'h00 || valid_m !== 1'b0 || bc_m !== 3'd0 || bc_l !== 3'd0) begin
            n_err++; $display("FAIL rmid_reset got %h v=%b bc=%0d exp 00 0 0", dout_m, valid_m, bc_m);
        end
        send_word_msb(8'hFF);
        n_cmp++;
        if (dout_m !== 8'hFF || dout_l !== 8'hFF || valid_m !== 1'b1) begin
            n_err++; $display("FAIL rmid_ff got %h/%h v=%b exp ff/ff 1", dout_m, dout_l, valid_m);
        end
        dout_ready = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            din = 1'($urandom);
            din_valid = ($urandom_range(0, 3) != 0);
            din_sof = ($urandom_range(0, 15) == 0);
            dout_ready = ($urandom_range(0, 2) != 0);
            overflow_clr = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 199) == 0);
            tick();
            n_cmp++;
            if (dout_m !== m_dout_m || dout_l !== m_dout_l || valid_m !== m_valid ||
                valid_l !== m_valid || ovf_m !== m_ovf || ovf_l !== m_ovf ||
                bc_m !== 3'(mq.size()) || bc_l !== 3'(mq.size())) begin
                n_err++;
                $display("FAIL rand_cycle%0d got d=%h/%h v=%b/%b o=%b/%b bc=%0d/%0d exp d=%h/%h v=%b o=%b bc=%0d",
                    c, dout_m, dout_l, valid_m, valid_l, ovf_m, ovf_l, bc_m, bc_l,
                    m_dout_m, m_dout_l, m_valid, m_ovf, mq.size());
            end
        end
        reset = 1'b0;
        din_valid = 1'b0;
        din_sof = 1'b0;
        overflow_clr = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_msb_a5();
        test_lsb_0f();
        test_overflow();
        test_back_to_back();
        test_sof();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
